// File: rtl/seg7_scan_mux.sv
// Four-digit time-multiplexed 7-segment driver with pending/display double buffering.
// Optional feature macro: SEG7_LEADING_ZERO_BLANK_EN (blank leading zeros on digits 3..1).
module seg7_scan_mux #(
    parameter int CLK_DIV    = 50000,
    parameter int GUARD      = 2,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    output logic [6:0]  seg_out,
    output logic        dp_out,
    output logic [3:0]  an_out,
    output logic        frame_done
);
    localparam int NUM_DIGITS = 4;
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GUARD_C  = CW'(GUARD);

    typedef enum logic [1:0] {SCAN0, SCAN1, SCAN2, SCAN3} scan_e;

    typedef struct packed {
        logic [NUM_DIGITS-1:0][3:0] dig;
        logic [NUM_DIGITS-1:0]      dp;
    } dbuf_t;

    function automatic logic [6:0] seg7_dec(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    scan_e                         state_q, state_d;
    logic [CW-1:0]                 cnt_q, cnt_d;
    dbuf_t                         pend_q, pend_d;
    dbuf_t                         disp_q, disp_d;
    logic [3:0]                    an_q, an_d;
    logic [6:0]                    seg_q, seg_d;
    logic                          dp_q, dp_d;
    logic                          fd_q, fd_d;

    logic                          cnt_wrap;
    logic                          boundary;
    logic                          in_guard;
    logic                          lit;
    logic [NUM_DIGITS-1:0][6:0]    dig_seg;
    logic [NUM_DIGITS-1:0]         blank;

    if (GUARD == 0) begin : g_noguard
        assign in_guard = 1'b0;
    end else begin : g_guard
        assign in_guard = (cnt_q < GUARD_C);
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] zero;
`endif

    // Per-digit decode; blanking only touches segments, never the anode or dp.
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        assign zero[g] = (disp_q.dig[g] == 4'h0);
        if (g == 0) begin : g_keep
            assign blank[g] = 1'b0;
        end else begin : g_lzb
            assign blank[g] = &zero[NUM_DIGITS-1:g];
        end
`else
        assign blank[g] = 1'b0;
`endif
        assign dig_seg[g] = blank[g] ? 7'h00 : seg7_dec(disp_q.dig[g]);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cnt_wrap = (cnt_q == CNT_LAST);
        boundary = en && cnt_wrap && (state_q == SCAN3);

        if (en) begin
            cnt_d = cnt_wrap ? '0 : cnt_q + 1'b1;
            if (cnt_wrap) begin
                case (state_q)
                    SCAN0:   state_d = SCAN1;
                    SCAN1:   state_d = SCAN2;
                    SCAN2:   state_d = SCAN3;
                    default: state_d = SCAN0;
                endcase
            end
        end

        pend_d = load ? dbuf_t'({digits_in, dp_in}) : pend_q;
        // Display buffer only changes on the frame wrap, so a frame never tears.
        disp_d = boundary ? pend_q : disp_q;

        lit   = en && !in_guard;
        an_d  = (lit ? (4'b0001 << state_q) : 4'b0000) ^ {4{ACTIVE_LOW}};
        seg_d = (lit ? dig_seg[state_q] : 7'h00) ^ {7{ACTIVE_LOW}};
        dp_d  = (lit ? disp_q.dp[state_q] : 1'b0) ^ ACTIVE_LOW;
        fd_d  = boundary;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SCAN0;
            cnt_q   <= '0;
            pend_q  <= '0;
            disp_q  <= '0;
            an_q    <= {4{ACTIVE_LOW}};
            seg_q   <= {7{ACTIVE_LOW}};
            dp_q    <= ACTIVE_LOW;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            disp_q  <= disp_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            fd_q    <= fd_d;
        end
    end

    assign an_out     = an_q;
    assign seg_out    = seg_q;
    assign dp_out     = dp_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux (CLK_DIV=4, GUARD=1, active-high): per-cycle scoreboard
// fed by a position-based display model, plus constant checks of shown digits.
module tb_seg7_scan_mux;
    localparam int CLK_DIV = 4;
    localparam int GUARD   = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [3:0]  an_out;
    logic        frame_done;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
    } obs_t;

    obs_t        sb_q[$];
    obs_t        exp_o;
    obs_t        got_o;
    int          n_vec = 0;
    int          n_err = 0;

    // Model: enabled-cycle position since reset, plus pending/display buffers.
    int          m_pos;
    logic [15:0] m_pend_dig, m_disp_dig;
    logic [3:0]  m_pend_dp, m_disp_dp;

    seg7_scan_mux #(.CLK_DIV(CLK_DIV), .GUARD(GUARD), .ACTIVE_LOW(1'b0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .seg_out    (seg_out),
        .dp_out     (dp_out),
        .an_out     (an_out),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    function automatic obs_t model_out(input logic en_v);
        obs_t o;
        int c, i;
        logic [3:0] d;
        logic blank;
        o = '0;
        if (en_v) begin
            c = m_pos % CLK_DIV;
            i = (m_pos / CLK_DIV) % 4;
            o.fd = ((m_pos % (4 * CLK_DIV)) == 4 * CLK_DIV - 1);
            if (c >= GUARD) begin
                d = m_disp_dig[i*4 +: 4];
                blank = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
                if (i > 0) begin
                    blank = 1'b1;
                    for (int j = i; j < 4; j++)
                        if (m_disp_dig[j*4 +: 4] != 4'h0) blank = 1'b0;
                end
`endif
                o.an  = 4'b0001 << i;
                o.seg = blank ? 7'h00 : seg_of(d);
                o.dp  = m_disp_dp[i];
            end
        end
        return o;
    endfunction

    task automatic model_reset();
        m_pos = 0;
        m_pend_dig = '0; m_pend_dp = '0;
        m_disp_dig = '0; m_disp_dp = '0;
        sb_q.delete();
    endtask

    // Called at a falling edge: drives one cycle, queues its expected output, advances model.
    task automatic drive_cycle(input logic en_v, input logic ld, input logic [15:0] d,
                               input logic [3:0] p);
        en = en_v; load = ld; digits_in = d; dp_in = p;
        sb_q.push_back(model_out(en_v));
        @(negedge clk);
        if (en_v) begin
            if ((m_pos % (4 * CLK_DIV)) == 4 * CLK_DIV - 1) begin
                m_disp_dig = m_pend_dig;
                m_disp_dp  = m_pend_dp;
            end
            m_pos++;
        end
        if (ld) begin
            m_pend_dig = d;
            m_pend_dp  = p;
        end
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; load = 1'b0; digits_in = '0; dp_in = '0;
        model_reset();
        repeat (2) @(negedge clk);
        got_o = {an_out, seg_out, dp_out, frame_done};
        n_vec++;
        if (got_o !== '0) begin
            n_err++;
            $display("FAIL reset_state: got %h want 0", got_o);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) drive_cycle(1'b1, 1'b0, 16'h0, 4'h0);
        sb_q.delete();
        #2 rst_n = 1'b0;
        #1;
        got_o = {an_out, seg_out, dp_out, frame_done};
        n_vec++;
        if (got_o !== '0) begin
            n_err++;
            $display("FAIL reset_async: got %h want 0", got_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 20; k++) begin
            drive_cycle(1'b0, 1'b0, 16'h0, 4'h0);
            exp_o = sb_q.pop_front();
            got_o = {an_out, seg_out, dp_out, frame_done};
            n_vec++;
            if (got_o !== exp_o) begin
                n_err++;
                $display("FAIL idle k=%0d: got an=%b seg=%h dp=%b fd=%b want an=%b seg=%h dp=%b fd=%b",
                         k, got_o.an, got_o.seg, got_o.dp, got_o.fd, exp_o.an, exp_o.seg, exp_o.dp, exp_o.fd);
            end
        end
    endtask

    task automatic test_scan_load();
        logic [6:0] seen_seg [4];
        logic [3:0] seen_dp;
        int         n_fd;
        n_fd = 0; seen_dp = '0;
        for (int j = 0; j < 4; j++) seen_seg[j] = 7'h00;
        for (int k = 0; k < 48; k++) begin
            drive_cycle(1'b1, k == 0, 16'h1234, 4'b0001);
            exp_o = sb_q.pop_front();
            got_o = {an_out, seg_out, dp_out, frame_done};
            n_vec++;
            if (got_o !== exp_o) begin
                n_err++;
                $display("FAIL scan k=%0d: got an=%b seg=%h dp=%b fd=%b want an=%b seg=%h dp=%b fd=%b",
                         k, got_o.an, got_o.seg, got_o.dp, got_o.fd, exp_o.an, exp_o.seg, exp_o.dp, exp_o.fd);
            end
            if (frame_done === 1'b1) n_fd++;
            if (k >= 32) begin
                for (int j = 0; j < 4; j++)
                    if (an_out === (4'b0001 << j)) begin
                        seen_seg[j] = seg_out;
                        seen_dp[j]  = dp_out;
                    end
            end
        end
        n_vec++;
        if (n_fd != 3) begin
            n_err++;
            $display("FAIL scan_frame_done_count: got %0d want 3", n_fd);
        end
        n_vec++;
        if (seen_seg[0] !== 7'h66 || seen_seg[1] !== 7'h4F || seen_seg[2] !== 7'h5B ||
            seen_seg[3] !== 7'h06 || seen_dp !== 4'b0001) begin
            n_err++;
            $display("FAIL scan_digits: got %h %h %h %h dp=%b want 66 4f 5b 06 dp=0001",
                     seen_seg[0], seen_seg[1], seen_seg[2], seen_seg[3], seen_dp);
        end
    endtask

    task automatic test_tear_free();
        logic        ld;
        logic [15:0] d;
        logic [3:0]  p;
        bit          ab_done, edge_done;
        ab_done = 0; edge_done = 0;
        for (int k = 0; k < 80; k++) begin
            ld = 1'b0; d = 16'h0; p = 4'h0;
            if (!ab_done && (m_pos % 16) == 5) begin
                ld = 1'b1; d = 16'hABCD; p = 4'b1000; ab_done = 1;
            end else if (ab_done && !edge_done && (m_pos % 16) == 15) begin
                ld = 1'b1; d = 16'h5678; p = 4'b0100; edge_done = 1;
            end
            drive_cycle(1'b1, ld, d, p);
            exp_o = sb_q.pop_front();
            got_o = {an_out, seg_out, dp_out, frame_done};
            n_vec++;
            if (got_o !== exp_o) begin
                n_err++;
                $display("FAIL tear_free k=%0d: got an=%b seg=%h dp=%b fd=%b want an=%b seg=%h dp=%b fd=%b",
                         k, got_o.an, got_o.seg, got_o.dp, got_o.fd, exp_o.an, exp_o.seg, exp_o.dp, exp_o.fd);
            end
        end
    endtask

    task automatic test_back_to_back();
        int          nld;
        logic        ld;
        logic [15:0] d;
        logic [3:0]  p;
        nld = 0;
        for (int k = 0; k < 48; k++) begin
            ld = 1'b0; d = 16'h0; p = 4'h0;
            if (nld < 3 && (m_pos % 16) == 12 + nld) begin
                ld = 1'b1;
                case (nld)
                    0:       begin d = 16'h1111; p = 4'b1111; end
                    1:       begin d = 16'h2222; p = 4'b0101; end
                    default: begin d = 16'h9876; p = 4'b0010; end
                endcase
                nld++;
            end
            drive_cycle(1'b1, ld, d, p);
            exp_o = sb_q.pop_front();
            got_o = {an_out, seg_out, dp_out, frame_done};
            n_vec++;
            if (got_o !== exp_o) begin
                n_err++;
                $display("FAIL back_to_back k=%0d: got an=%b seg=%h dp=%b fd=%b want an=%b seg=%h dp=%b fd=%b",
                         k, got_o.an, got_o.seg, got_o.dp, got_o.fd, exp_o.an, exp_o.seg, exp_o.dp, exp_o.fd);
            end
        end
    endtask

    task automatic test_enable_gating();
        int   gated, rem;
        logic e;
        bit   seen3;
        gated = 0; rem = 0; seen3 = 0;
        for (int k = 0; k < 50; k++) begin
            e = 1'b1;
            if (gated < 5 && (gated > 0 || (m_pos % 16) == 10)) begin
                e = 1'b0;
                gated++;
            end
            drive_cycle(e, 1'b0, 16'h0, 4'h0);
            exp_o = sb_q.pop_front();
            got_o = {an_out, seg_out, dp_out, frame_done};
            n_vec++;
            if (got_o !== exp_o) begin
                n_err++;
                $display("FAIL enable k=%0d: got an=%b seg=%h dp=%b fd=%b want an=%b seg=%h dp=%b fd=%b",
                         k, got_o.an, got_o.seg, got_o.dp, got_o.fd, exp_o.an, exp_o.seg, exp_o.dp, exp_o.fd);
            end
            if (gated == 5 && e && !seen3) begin
                if (an_out === 4'b0100) rem++;
                else if (an_out === 4'b1000) seen3 = 1;
            end
        end
        n_vec++;
        if (rem != 2) begin
            n_err++;
            $display("FAIL enable_resume_remaining: got %0d digit-2 cycles want 2", rem);
        end
    endtask

    task automatic test_lzb();
        logic [6:0] seen_seg [4];
        logic [6:0] want_hi;
        for (int j = 0; j < 4; j++) seen_seg[j] = 7'h7F;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        want_hi = 7'h00;
`else
        want_hi = 7'h3F;
`endif
        for (int k = 0; k < 48; k++) begin
            drive_cycle(1'b1, k == 0, 16'h0050, 4'h0);
            exp_o = sb_q.pop_front();
            got_o = {an_out, seg_out, dp_out, frame_done};
            n_vec++;
            if (got_o !== exp_o) begin
                n_err++;
                $display("FAIL lzb k=%0d: got an=%b seg=%h dp=%b fd=%b want an=%b seg=%h dp=%b fd=%b",
                         k, got_o.an, got_o.seg, got_o.dp, got_o.fd, exp_o.an, exp_o.seg, exp_o.dp, exp_o.fd);
            end
            if (k >= 32)
                for (int j = 0; j < 4; j++)
                    if (an_out === (4'b0001 << j)) seen_seg[j] = seg_out;
        end
        n_vec++;
        if (seen_seg[3] !== want_hi || seen_seg[2] !== want_hi ||
            seen_seg[1] !== 7'h6D || seen_seg[0] !== 7'h3F) begin
            n_err++;
            $display("FAIL lzb_digits: got %h %h %h %h want %h %h 6d 3f",
                     seen_seg[3], seen_seg[2], seen_seg[1], seen_seg[0], want_hi, want_hi);
        end
    endtask

    initial begin
        test_reset();
        test_scan_load();
        test_tear_free();
        test_back_to_back();
        test_enable_gating();
        test_lzb();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
